// File: rtl/exec_mon_pkg.sv
// Shared types and default parameters for the execution monitor.
package exec_mon_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CauseNone    = 2'd0,
    CauseIllegal = 2'd1,
    CauseBp      = 2'd2,
    CauseLimit   = 2'd3
  } halt_cause_e;

  localparam int unsigned DefPcW        = 32;
  localparam int unsigned DefInstrW     = 32;
  localparam int unsigned DefMaxCycles  = 250;
  localparam int unsigned DefNumBp      = 2;
  localparam int unsigned DefTraceDepth = 16;

endpackage

// File: rtl/trace_fifo.sv
// Circular trace buffer: drops the oldest entry when written while full.
module trace_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 96
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             full, empty;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

  // A push wins over a pop; the monitor never requests both in one cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (push_i) begin
      wr_ptr_q <= wr_ptr_q + AW'(1);
      if (full) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end else begin
        count_q <= count_q + (AW+1)'(1);
      end
    end else if (pop_i && !empty) begin
      rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q  <= count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clear_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = empty ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/exec_monitor.sv
// Run-control monitor: counts cycles/retires, halts on illegal, breakpoint
// or cycle limit, and keeps a trace of the most recent retired instructions.
module exec_monitor
  import exec_mon_pkg::*;
#(
  parameter int unsigned PC_W        = DefPcW,
  parameter int unsigned INSTR_W     = DefInstrW,
  parameter int unsigned MAX_CYCLES  = DefMaxCycles,
  parameter int unsigned NUM_BP      = DefNumBp,
  parameter int unsigned TRACE_DEPTH = DefTraceDepth
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               start_i,
  input  logic                               resume_i,
  input  logic                               valid_i,
  input  logic [PC_W-1:0]                    pc_i,
  input  logic [INSTR_W-1:0]                 instr_i,
  input  logic [PC_W-1:0]                    npc_i,
  input  logic [NUM_BP-1:0]                  bp_en_i,
  input  logic [NUM_BP*PC_W-1:0]             bp_addr_i,
  input  logic                               trace_rd_i,
  output logic                               run_o,
  output logic                               halted_o,
  output logic [1:0]                         halt_cause_o,
  output logic [$clog2(MAX_CYCLES+1)-1:0]    cycle_cnt_o,
  output logic [$clog2(MAX_CYCLES+1)-1:0]    retired_cnt_o,
  output logic [PC_W-1:0]                    trace_pc_o,
  output logic [INSTR_W-1:0]                 trace_instr_o,
  output logic [PC_W-1:0]                    trace_npc_o,
  output logic [$clog2(TRACE_DEPTH):0]       trace_count_o
);

  localparam int unsigned CNT_W = $clog2(MAX_CYCLES + 1);
  localparam int unsigned TW    = 2 * PC_W + INSTR_W;
  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_CYCLES);

  state_e            state_q, state_d;
  halt_cause_e       cause_q, cause_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]  retired_cnt_q, retired_cnt_d;
  logic              skip_q, skip_d;
  logic              bp_match, illegal, bp_hit;
  logic              trace_push, trace_pop, trace_clear;
  logic [TW-1:0]     trace_rdata;

  always_comb begin
    bp_match = 1'b0;
    for (int k = 0; k < NUM_BP; k++) begin
      if (bp_en_i[k] && (pc_i == bp_addr_i[k*PC_W +: PC_W])) begin
        bp_match = 1'b1;
      end
    end
  end

  assign illegal = valid_i && ((instr_i == '0) || (instr_i == '1));
  // The first retire after a resume steps past the breakpoint we stopped on.
  assign bp_hit  = valid_i && bp_match && !skip_q;

  always_comb begin
    state_d       = state_q;
    cause_d       = cause_q;
    cycle_cnt_d   = cycle_cnt_q;
    retired_cnt_d = retired_cnt_q;
    skip_d        = skip_q;
    trace_push    = 1'b0;
    trace_clear   = 1'b0;

    unique case (state_q)
      StIdle, StHalt: begin
        if (start_i) begin
          state_d       = StRun;
          cause_d       = CauseNone;
          cycle_cnt_d   = '0;
          retired_cnt_d = '0;
          skip_d        = 1'b0;
          trace_clear   = 1'b1;
        end else if ((state_q == StHalt) && resume_i && (cycle_cnt_q != MaxCnt)) begin
          state_d = StRun;
          cause_d = CauseNone;
          skip_d  = 1'b1;
        end
      end
      StRun: begin
        if (cycle_cnt_q != MaxCnt) begin
          cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end
        if (valid_i) begin
          trace_push = 1'b1;
          skip_d     = 1'b0;
          if (retired_cnt_q != MaxCnt) begin
            retired_cnt_d = retired_cnt_q + CNT_W'(1);
          end
        end
        if (illegal) begin
          state_d = StHalt;
          cause_d = CauseIllegal;
        end else if (bp_hit) begin
          state_d = StHalt;
          cause_d = CauseBp;
        end else if (cycle_cnt_d == MaxCnt) begin
          state_d = StHalt;
          cause_d = CauseLimit;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= StIdle;
      cause_q       <= CauseNone;
      cycle_cnt_q   <= '0;
      retired_cnt_q <= '0;
      skip_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cause_q       <= cause_d;
      cycle_cnt_q   <= cycle_cnt_d;
      retired_cnt_q <= retired_cnt_d;
      skip_q        <= skip_d;
    end
  end

  assign trace_pop = trace_rd_i && (state_q != StRun);

  trace_fifo #(
    .DEPTH (TRACE_DEPTH),
    .WIDTH (TW)
  ) u_trace (
    .clk     (clk),
    .rstn    (rstn),
    .clear_i (trace_clear),
    .push_i  (trace_push),
    .pop_i   (trace_pop),
    .wdata_i ({pc_i, instr_i, npc_i}),
    .rdata_o (trace_rdata),
    .count_o (trace_count_o)
  );

  assign {trace_pc_o, trace_instr_o, trace_npc_o} = trace_rdata;

  assign run_o         = (state_q == StRun);
  assign halted_o      = (state_q == StHalt);
  assign halt_cause_o  = cause_q;
  assign cycle_cnt_o   = cycle_cnt_q;
  assign retired_cnt_o = retired_cnt_q;

endmodule

// File: tb/tb_exec_monitor.sv
// Directed bench for exec_monitor with a trace scoreboard.
module tb_exec_monitor;

  logic        clk;
  logic        rstn;
  logic        start_i, resume_i, valid_i, trace_rd_i;
  logic [31:0] pc_i, instr_i, npc_i;
  logic [1:0]  bp_en_i;
  logic [63:0] bp_addr_i;
  logic        run_o, halted_o;
  logic [1:0]  halt_cause_o;
  logic [7:0]  cycle_cnt_o, retired_cnt_o;
  logic [31:0] trace_pc_o, trace_instr_o, trace_npc_o;
  logic [4:0]  trace_count_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] npc;
  } tr_t;

  tr_t exp_q[$];

  exec_monitor dut (
    .clk           (clk),
    .rstn          (rstn),
    .start_i       (start_i),
    .resume_i      (resume_i),
    .valid_i       (valid_i),
    .pc_i          (pc_i),
    .instr_i       (instr_i),
    .npc_i         (npc_i),
    .bp_en_i       (bp_en_i),
    .bp_addr_i     (bp_addr_i),
    .trace_rd_i    (trace_rd_i),
    .run_o         (run_o),
    .halted_o      (halted_o),
    .halt_cause_o  (halt_cause_o),
    .cycle_cnt_o   (cycle_cnt_o),
    .retired_cnt_o (retired_cnt_o),
    .trace_pc_o    (trace_pc_o),
    .trace_instr_o (trace_instr_o),
    .trace_npc_o   (trace_npc_o),
    .trace_count_o (trace_count_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_resume();
    resume_i = 1'b1;
    tick();
    resume_i = 1'b0;
  endtask

  // Drives one retire while the monitor is expected to be running.
  task automatic retire(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] npc);
    tr_t e;
    valid_i = 1'b1;
    pc_i    = pc;
    instr_i = instr;
    npc_i   = npc;
    e.pc = pc;
    e.instr = instr;
    e.npc = npc;
    if (exp_q.size() == 16) void'(exp_q.pop_front());
    exp_q.push_back(e);
    tick();
    valid_i = 1'b0;
  endtask

  task automatic pop_and_check(input string tag);
    tr_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_pc"}, 64'(trace_pc_o), 64'(e.pc));
      check({tag, "_instr"}, 64'(trace_instr_o), 64'(e.instr));
      check({tag, "_npc"}, 64'(trace_npc_o), 64'(e.npc));
    end
    trace_rd_i = 1'b1;
    tick();
    trace_rd_i = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    {start_i, resume_i, valid_i, trace_rd_i} = '0;
    pc_i = '0; instr_i = '0; npc_i = '0;
    bp_en_i = '0; bp_addr_i = '0;
    #1;
    check("rst_run", 64'(run_o), 64'd0);
    check("rst_halted", 64'(halted_o), 64'd0);
    check("rst_cause", 64'(halt_cause_o), 64'd0);
    check("rst_cycle", 64'(cycle_cnt_o), 64'd0);
    check("rst_tcount", 64'(trace_count_o), 64'd0);
    check("rst_tpc", 64'(trace_pc_o), 64'd0);
    tick();
    tick();
    rstn = 1'b1;
    tick();
    check("idle_run", 64'(run_o), 64'd0);

    // Cycle limit with a retire every cycle
    do_start();
    check("lim_run0", 64'(run_o), 64'd1);
    check("lim_cycle0", 64'(cycle_cnt_o), 64'd0);
    for (int i = 0; i < 250; i++) retire(32'(i * 4), 32'h0000_0013, 32'(i * 4 + 4));
    check("lim_halted", 64'(halted_o), 64'd1);
    check("lim_run", 64'(run_o), 64'd0);
    check("lim_cause", 64'(halt_cause_o), 64'd3);
    check("lim_cycle", 64'(cycle_cnt_o), 64'd250);
    check("lim_retired", 64'(retired_cnt_o), 64'd250);
    check("lim_tcount", 64'(trace_count_o), 64'd16);
    pop_and_check("lim_pop0");
    pop_and_check("lim_pop1");
    check("lim_tcount_pop", 64'(trace_count_o), 64'd14);
    do_resume();
    check("lim_resume_ign", 64'(halted_o), 64'd1);
    check("lim_resume_cause", 64'(halt_cause_o), 64'd3);

    // Breakpoint, resume skip, re-hit
    bp_addr_i = {32'h0000_0100, 32'h0000_0010};
    bp_en_i   = 2'b01;
    do_start();
    check("bp_clr_cycle", 64'(cycle_cnt_o), 64'd0);
    check("bp_clr_tcount", 64'(trace_count_o), 64'd0);
    check("bp_clr_cause", 64'(halt_cause_o), 64'd0);
    for (int i = 0; i < 5; i++) retire(32'(i * 4), 32'h0000_0013, 32'(i * 4 + 4));
    check("bp_halted", 64'(halted_o), 64'd1);
    check("bp_cause", 64'(halt_cause_o), 64'd2);
    check("bp_retired", 64'(retired_cnt_o), 64'd5);
    check("bp_cycle", 64'(cycle_cnt_o), 64'd5);
    do_resume();
    check("bp_res_run", 64'(run_o), 64'd1);
    check("bp_res_cause", 64'(halt_cause_o), 64'd0);
    check("bp_res_retired", 64'(retired_cnt_o), 64'd5);
    check("bp_res_tcount", 64'(trace_count_o), 64'd5);
    trace_rd_i = 1'b1;
    retire(32'h10, 32'h0000_0013, 32'h14);
    trace_rd_i = 1'b0;
    check("bp_skip_run", 64'(run_o), 64'd1);
    check("bp_rd_in_run", 64'(trace_count_o), 64'd6);
    retire(32'h14, 32'h0000_0013, 32'h10);
    check("bp_run2", 64'(run_o), 64'd1);
    retire(32'h10, 32'h0000_0013, 32'h14);
    check("bp_rehit", 64'(halt_cause_o), 64'd2);
    check("bp_rehit_ret", 64'(retired_cnt_o), 64'd8);
    check("bp_rehit_cyc", 64'(cycle_cnt_o), 64'd8);

    // Illegal + breakpoint + limit on the same edge
    do_start();
    for (int i = 0; i < 249; i++) retire(32'h1000 + 32'(i * 4), 32'h0000_0013, 32'h1004 + 32'(i * 4));
    check("pri_run", 64'(run_o), 64'd1);
    check("pri_cycle249", 64'(cycle_cnt_o), 64'd249);
    retire(32'h10, 32'hFFFF_FFFF, 32'h14);
    check("pri_cause", 64'(halt_cause_o), 64'd1);
    check("pri_cycle", 64'(cycle_cnt_o), 64'd250);
    check("pri_halted", 64'(halted_o), 64'd1);

    // Breakpoint beats cycle limit
    do_start();
    for (int i = 0; i < 249; i++) retire(32'h1000 + 32'(i * 4), 32'h0000_0013, 32'h1004 + 32'(i * 4));
    retire(32'h10, 32'h0000_0013, 32'h14);
    check("pri_bp_cause", 64'(halt_cause_o), 64'd2);

    // All-zero instruction
    do_start();
    retire(32'h2000, 32'h0000_0013, 32'h2004);
    retire(32'h2004, 32'h0000_0013, 32'h2008);
    retire(32'h2008, 32'h0000_0000, 32'h200C);
    check("zero_cause", 64'(halt_cause_o), 64'd1);
    check("zero_retired", 64'(retired_cnt_o), 64'd3);

    // Trace overwrite and drain
    bp_addr_i = {32'h0000_004C, 32'h0000_0010};
    bp_en_i   = 2'b10;
    do_start();
    for (int i = 0; i < 20; i++) retire(32'(i * 4), 32'h0100_0000 | 32'(i), 32'(i * 4 + 4));
    check("tr_halted", 64'(halted_o), 64'd1);
    check("tr_tcount", 64'(trace_count_o), 64'd16);
    check("tr_first_pc", 64'(trace_pc_o), 64'h10);
    for (int i = 0; i < 16; i++) pop_and_check($sformatf("tr_pop%0d", i));
    check("tr_empty", 64'(trace_count_o), 64'd0);
    check("tr_empty_pc", 64'(trace_pc_o), 64'd0);
    trace_rd_i = 1'b1;
    tick();
    trace_rd_i = 1'b0;
    check("tr_pop17", 64'(trace_count_o), 64'd0);

    // Start ignored in RUN, then reset mid-run
    bp_en_i = 2'b00;
    do_start();
    for (int i = 0; i < 3; i++) retire(32'(i * 4), 32'h0000_0013, 32'(i * 4 + 4));
    start_i = 1'b1;
    retire(32'hC, 32'h0000_0013, 32'h10);
    start_i = 1'b0;
    check("run_start_ign", 64'(cycle_cnt_o), 64'd4);
    for (int i = 4; i < 7; i++) retire(32'(i * 4), 32'h0000_0013, 32'(i * 4 + 4));
    check("mid_cycle7", 64'(cycle_cnt_o), 64'd7);
    rstn = 1'b0;
    #1;
    check("mid_run", 64'(run_o), 64'd0);
    check("mid_cycle", 64'(cycle_cnt_o), 64'd0);
    check("mid_retired", 64'(retired_cnt_o), 64'd0);
    check("mid_tcount", 64'(trace_count_o), 64'd0);
    valid_i = 1'b1;
    tick();
    tick();
    check("mid_hold_tcount", 64'(trace_count_o), 64'd0);
    rstn = 1'b1;
    valid_i = 1'b0;
    tick();
    check("mid_idle_run", 64'(run_o), 64'd0);
    check("mid_idle_halt", 64'(halted_o), 64'd0);
    check("mid_idle_cycle", 64'(cycle_cnt_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
